// File: rtl/ps2_keyboard_tx_if.sv
// Byte-stream handshake into the PS/2 keyboard transmitter.
interface ps2_keyboard_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard emulator: buffers scan codes in a FIFO and
// serializes each as an 11-bit frame (start, 8 data LSB first, odd parity, stop).
module ps2_keyboard_tx #(
    parameter int unsigned CLK_DIV    = 8,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    ps2_keyboard_tx_if.slave         in_if,
    output logic                     ps2_clk,
    output logic                     ps2_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic [7:0]    head;
    logic [10:0]   frame_new;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_n;
    logic [9:0]    shift, shift_n;    // frame bits 1..10 still to be sent
    logic          clk_n, data_n;

    assign in_if.in_ready = (fifo_count != FULL_CNT);
    assign push      = in_if.in_valid & in_if.in_ready;
    assign busy      = (fifo_count != '0) || (state != IDLE);
    assign head      = mem[rd_ptr];
    assign frame_new = {1'b1, ~^head, head, 1'b0};

    // FIFO storage, pointers and occupancy; a pop frees a slot only next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_if.in_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Serializer state, counters and registered PS/2 lines
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '1;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            ps2_clk  <= clk_n;
            ps2_data <= data_n;
        end
    end

    // Next-state and next line values for the frame sequencer
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        clk_n   = ps2_clk;
        data_n  = ps2_data;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                clk_n  = 1'b1;
                data_n = 1'b1;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    shift_n = frame_new[10:1];
                    data_n  = frame_new[0];
                    bit_n   = '0;
                    cnt_n   = '0;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    clk_n   = 1'b0;
                    state_n = LOW;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            LOW: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    clk_n = 1'b1;
                    if (bit_idx != 4'd10) begin
                        bit_n   = bit_idx + 4'd1;
                        data_n  = shift[0];
                        shift_n = {1'b1, shift[9:1]};
                        state_n = HIGH;
                    end else begin
                        data_n  = 1'b1;
                        state_n = GAP;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            GAP: begin
                clk_n  = 1'b1;
                data_n = 1'b1;
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
